// File: rtl/rdma_framer.sv
// rdma_framer: prefixes each AXI write burst with a magic/seq/address header beat on a registered AXI-Stream.
// Define RDMA_FRAMER_STATS_EN to add frame_count/beat_count output-handshake counters.
module rdma_framer #(
  parameter int          DATA_WIDTH = 512,
  parameter int          ADDR_WIDTH = 64,
  parameter logic [15:0] MAGIC      = 16'hFBFB
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [ADDR_WIDTH-1:0] AXIS_ADDR_TDATA,
  input  logic                  AXIS_ADDR_TVALID,
  output logic                  AXIS_ADDR_TREADY,
  input  logic [DATA_WIDTH-1:0] AXIS_DATA_TDATA,
  input  logic                  AXIS_DATA_TVALID,
  input  logic                  AXIS_DATA_TLAST,
  output logic                  AXIS_DATA_TREADY,
  output logic [DATA_WIDTH-1:0] AXIS_TX_TDATA,
  output logic                  AXIS_TX_TVALID,
  output logic                  AXIS_TX_TLAST,
  input  logic                  AXIS_TX_TREADY
`ifdef RDMA_FRAMER_STATS_EN
  ,
  output logic [31:0]           frame_count,
  output logic [63:0]           beat_count
`endif
);
  typedef enum logic {IDLE, DATA} state_e;
  state_e                state_q, state_d;
  logic [31:0]           seq_q, seq_d;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d, hdr;
  logic                  tvalid_q, tvalid_d, tlast_q, tlast_d;
  logic                  room, a_hs, d_hs;
  always_comb begin
    room = !tvalid_q | AXIS_TX_TREADY;
    // readies are held low during reset so nothing is accepted while resetn is asserted
    AXIS_ADDR_TREADY = resetn & room & (state_q == IDLE);
    AXIS_DATA_TREADY = resetn & room & (state_q == DATA);
    a_hs = AXIS_ADDR_TVALID & AXIS_ADDR_TREADY;
    d_hs = AXIS_DATA_TVALID & AXIS_DATA_TREADY;
    hdr = '0;
    hdr[15:0] = MAGIC;
    hdr[63:32] = seq_q;
    hdr[64 +: ADDR_WIDTH] = AXIS_ADDR_TDATA;
    tvalid_d = a_hs | d_hs | (tvalid_q & !AXIS_TX_TREADY);
    tdata_d = a_hs ? hdr : d_hs ? AXIS_DATA_TDATA : tdata_q;
    tlast_d = a_hs ? 1'b0 : d_hs ? AXIS_DATA_TLAST : tlast_q;
    state_d = a_hs ? DATA : (d_hs & AXIS_DATA_TLAST) ? IDLE : state_q;
    seq_d = seq_q + 32'(d_hs & AXIS_DATA_TLAST);
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      seq_q    <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      seq_q    <= seq_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
    end
  end
  assign AXIS_TX_TDATA  = tdata_q;
  assign AXIS_TX_TVALID = tvalid_q;
  assign AXIS_TX_TLAST  = tlast_q;
`ifdef RDMA_FRAMER_STATS_EN
  logic [31:0] frame_q, frame_d;
  logic [63:0] beat_q, beat_d;
  logic        o_hs;
  always_comb begin
    o_hs = tvalid_q & AXIS_TX_TREADY;
    frame_d = frame_q + 32'(o_hs & tlast_q);
    beat_d = beat_q + 64'(o_hs);
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      frame_q <= '0;
      beat_q  <= '0;
    end else begin
      frame_q <= frame_d;
      beat_q  <= beat_d;
    end
  end
  assign frame_count = frame_q;
  assign beat_count  = beat_q;
`endif
endmodule

// File: tb/tb_rdma_framer.sv
// tb_rdma_framer: queue-fed input drivers, expected-beat scoreboard and an independent output monitor.
`timescale 1ns/100ps
module tb_rdma_framer;
  typedef struct packed {logic [511:0] d; logic l;} beat_t;
  logic         clk = 0, resetn;
  logic [63:0]  a_d;
  logic         a_v, a_r, d_v, d_l, d_r, tx_v, tx_l, tx_r;
  logic [511:0] d_d, tx_d, hold_d;
  logic         hold_l, stall_prev = 0, a_hs = 0, d_hs = 0;
  logic [63:0]  aq[$];
  beat_t        dq[$], sb[$];
  int           pcyc[$];
  int           checks = 0, failures = 0, pops = 0, cyc = 0;
  logic [31:0]  exp_seq = 0;
`ifdef RDMA_FRAMER_STATS_EN
  logic [31:0] frame_count;
  logic [63:0] beat_count;
`endif
  rdma_framer dut (
    .clk(clk), .resetn(resetn),
    .AXIS_ADDR_TDATA(a_d), .AXIS_ADDR_TVALID(a_v), .AXIS_ADDR_TREADY(a_r),
    .AXIS_DATA_TDATA(d_d), .AXIS_DATA_TVALID(d_v), .AXIS_DATA_TLAST(d_l), .AXIS_DATA_TREADY(d_r),
    .AXIS_TX_TDATA(tx_d), .AXIS_TX_TVALID(tx_v), .AXIS_TX_TLAST(tx_l), .AXIS_TX_TREADY(tx_r)
`ifdef RDMA_FRAMER_STATS_EN
    , .frame_count(frame_count), .beat_count(beat_count)
`endif
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc  <= cyc + 1;
    a_hs <= a_v & a_r;
    d_hs <= d_v & d_r;
  end
  task automatic chk(input string n, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", n, act, exp);
    end
  endtask
  function automatic logic [511:0] beat(input logic [31:0] b, input int i);
    return {16{b + 32'(i)}};
  endfunction
  function automatic logic [511:0] hdr(input logic [31:0] s, input logic [63:0] a);
    logic [511:0] h = '0;
    h[15:0] = 16'hFBFB;
    h[63:32] = s;
    h[127:64] = a;
    return h;
  endfunction
  always @(negedge clk) begin
    if (!a_v || a_hs) begin
      a_v = aq.size() > 0;
      if (a_v) a_d = aq.pop_front();
    end
    if (!d_v || d_hs) begin
      d_v = dq.size() > 0;
      if (d_v) {d_d, d_l} = dq.pop_front();
    end
  end
  always @(negedge clk) begin
    beat_t e;
    #3;
    if (resetn) begin
      if (stall_prev) chk("stall_hold", {tx_v, tx_l, tx_d}, {1'b1, hold_l, hold_d});
      stall_prev = tx_v && !tx_r;
      if (stall_prev) begin
        hold_d = tx_d;
        hold_l = tx_l;
        chk("stall_data_tready", d_r, 0);
      end
      if (tx_v && tx_r) begin
        pops++;
        pcyc.push_back(cyc);
        if (sb.size() == 0) chk("unexpected_beat", {tx_l, tx_d}, 0);
        else begin
          e = sb.pop_front();
          chk("tx_data", tx_d, e.d);
          chk("tx_last", tx_l, e.l);
        end
      end
    end
  end
  task automatic exp_frame(input logic [63:0] a, input logic [31:0] b, input int n);
    sb.push_back('{hdr(exp_seq, a), 1'b0});
    exp_seq++;
    for (int i = 0; i < n; i++) sb.push_back('{beat(b, i), i == n - 1});
  endtask
  task automatic give_data(input logic [31:0] b, input int n);
    for (int i = 0; i < n; i++) dq.push_back('{beat(b, i), i == n - 1});
  endtask
  task automatic push_frame(input logic [63:0] a, input logic [31:0] b, input int n);
    exp_frame(a, b, n);
    give_data(b, n);
    aq.push_back(a);
  endtask
  task automatic wait_done();
    bit done = 0;
    for (int i = 0; i < 2000 && !done; i++) begin
      @(negedge clk);
      #4;
      done = sb.size() == 0 && aq.size() == 0 && dq.size() == 0 && !a_v && !d_v;
    end
    chk("drain", 512'(done), 1);
  endtask
  task automatic wait_pops(input int n);
    for (int i = 0; i < 500 && pops < n; i++) @(negedge clk);
    chk("pops_reach", 512'(pops >= n), 1);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int n0;
    resetn = 0; tx_r = 1; a_v = 0; d_v = 0; a_d = 0; d_d = 0; d_l = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_tvalid", tx_v, 0);
    chk("rst_tlast", tx_l, 0);
    chk("rst_tdata", tx_d, 0);
    chk("rst_addr_tready", a_r, 0);
    chk("rst_data_tready", d_r, 0);
    @(negedge clk) resetn = 1;
    // single frame, 5 back-to-back output beats
    push_frame(64'h0000_1000_2000_3000, 32'hA000_0000, 4);
    wait_done();
    chk("single_span", 512'(pcyc[$] - pcyc[pcyc.size() - 5]), 4);
    // three two-beat frames presented together
    for (int f = 0; f < 3; f++) push_frame(64'h1111_0000_0000_0000 + 64'(f), 32'hB000_0000 + 32'(f << 8), 2);
    wait_done();
    chk("b2b_span", 512'(pcyc[$] - pcyc[pcyc.size() - 9]), 8);
    // backpressure mid-frame
    n0 = pops;
    push_frame(64'h2222_3333_4444_5555, 32'hC000_0000, 6);
    wait_pops(n0 + 3);
    @(negedge clk) tx_r = 0;
    repeat (5) @(negedge clk);
    tx_r = 1;
    wait_done();
    // data ahead of address; second address presented during DATA
    exp_frame(64'hAAAA_0000_0000_0001, 32'hD000_0000, 2);
    exp_frame(64'hBBBB_0000_0000_0002, 32'hD100_0000, 3);
    exp_frame(64'hCCCC_0000_0000_0003, 32'hD200_0000, 1);
    give_data(32'hD000_0000, 2);
    repeat (3) begin
      @(negedge clk);
      #2;
      chk("data_held_idle", {d_v, d_r}, 2'b10);
    end
    aq.push_back(64'hAAAA_0000_0000_0001);
    aq.push_back(64'hBBBB_0000_0000_0002);
    aq.push_back(64'hCCCC_0000_0000_0003);
    for (int i = 0; i < 200 && sb.size() > 5; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    #2;
    chk("addr_held_data", {a_v, a_r, d_r}, 3'b101);
    give_data(32'hD100_0000, 3);
    give_data(32'hD200_0000, 1);
    wait_done();
    // sequence wrap
    force dut.seq_q = 32'hFFFF_FFFF;
    @(posedge clk);
    @(negedge clk) release dut.seq_q;
    exp_seq = 32'hFFFF_FFFF;
    push_frame(64'h0000_0000_DEAD_BEEF, 32'hE000_0000, 1);
    push_frame(64'h0000_0000_CAFE_F00D, 32'hE100_0000, 2);
    wait_done();
    // asynchronous reset mid-frame
    n0 = pops;
    push_frame(64'h7777_7777_7777_7777, 32'hF000_0000, 4);
    wait_pops(n0 + 2);
    @(posedge clk);
    #2 resetn = 0;
    #1;
    chk("async_rst_tvalid", tx_v, 0);
    chk("async_rst_tdata", {tx_l, tx_d}, 0);
    chk("async_rst_addr_tready", a_r, 0);
    aq.delete(); dq.delete(); sb.delete();
    a_v = 0; d_v = 0; exp_seq = 0;
    repeat (2) @(negedge clk);
    resetn = 1;
    push_frame(64'h0000_0000_0000_0042, 32'h1200_0000, 2);
    wait_done();
    // clean reset, then three four-beat frames for the counters
    @(negedge clk) resetn = 0;
    @(negedge clk) resetn = 1;
    exp_seq = 0;
    for (int f = 0; f < 3; f++) push_frame(64'h5000 + 64'(f), 32'h3300_0000 + 32'(f << 8), 4);
    wait_done();
`ifdef RDMA_FRAMER_STATS_EN
    chk("frame_count", frame_count, 3);
    chk("beat_count", beat_count, 15);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
